// File: rtl/t5_pkg.sv
// Shared definitions for the T5 multi-hart register file: default widths and FSM states.
package t5_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned HARTS_DEF = 4;

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_e;

endpackage

// File: rtl/t5_mrf_if.sv
// Access bus of the T5 multi-hart register file: pipeline enable, two read ports, one write port, ready.
interface t5_mrf_if
  import t5_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int HW   = 2,
  parameter int RW   = 5
);

  logic            sena;
  logic [HW-1:0]   fhart;
  logic [RW-1:0]   rs1a;
  logic [RW-1:0]   rs2a;
  logic [XLEN-1:0] rs1d;
  logic [XLEN-1:0] rs2d;
  logic [HW-1:0]   mhart;
  logic [RW-1:0]   rd0a;
  logic [XLEN-1:0] rd0d;
  logic            mwre;
  logic            rdy;

  modport master (
    output sena, fhart, rs1a, rs2a, mhart, rd0a, rd0d, mwre,
    input  rs1d, rs2d, rdy
  );

  modport slave (
    input  sena, fhart, rs1a, rs2a, mhart, rd0a, rd0d, mwre,
    output rs1d, rs2d, rdy
  );

endinterface

// File: rtl/t5_rfbank.sv
// One storage bank: a single write port and one synchronous read port (read-first on collision).
module t5_rfbank
  import t5_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/t5_mrf.sv
// Multi-hart register file: clears itself after reset, then serves two read ports and one write port.
// Define T5_MRF_BYPASS_EN to forward a same-edge write to a matching read (write-first).
module t5_mrf
  import t5_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int HARTS = HARTS_DEF,
  parameter int NREG  = 32
) (
  input  logic     sclk,
  input  logic     srst,
  t5_mrf_if.slave  bus
);

  localparam int HW    = $clog2(HARTS);
  localparam int RW    = $clog2(NREG);
  localparam int AW    = HW + RW;
  localparam int DEPTH = HARTS * NREG;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;

  logic            running;
  logic            wrQual;
  logic            bankWe;
  logic [AW-1:0]   bankWaddr;
  logic [XLEN-1:0] bankWdata;

  logic [RW-1:0]   rsA    [2];
  logic [XLEN-1:0] bankRd [2];
  logic [XLEN-1:0] rsD    [2];
  logic [1:0]      valid_q;

  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q <= CLR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep advances every cycle regardless of sena; RUN is left only through srst.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLR;
    endcase
  end

  assign running   = (state_q == RUN);
  assign wrQual    = running && bus.sena && bus.mwre && (bus.rd0a != '0) && !srst;
  assign bankWe    = !srst && (!running || wrQual);
  assign bankWaddr = running ? {bus.mhart, bus.rd0a} : cnt_q;
  assign bankWdata = running ? bus.rd0d : '0;

  assign rsA[0] = bus.rs1a;
  assign rsA[1] = bus.rs2a;

  for (genvar p = 0; p < 2; p++) begin : g_port
    t5_rfbank #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk_i   (sclk),
      .we_i    (bankWe),
      .waddr_i (bankWaddr),
      .wdata_i (bankWdata),
      .re_i    (bus.sena),
      .raddr_i ({bus.fhart, rsA[p]}),
      .rdata_o (bankRd[p])
    );
  end

  // A read is only valid if it was sampled in RUN and did not target x0.
  always_ff @(posedge sclk) begin
    if (srst) begin
      valid_q <= '0;
    end else if (bus.sena) begin
      for (int p = 0; p < 2; p++) begin
        valid_q[p] <= running && (rsA[p] != '0);
      end
    end
  end

`ifdef T5_MRF_BYPASS_EN
  logic [1:0]      byp_q;
  logic [XLEN-1:0] bypData_q;

  always_ff @(posedge sclk) begin
    if (srst) begin
      byp_q     <= '0;
      bypData_q <= '0;
    end else if (bus.sena) begin
      for (int p = 0; p < 2; p++) begin
        byp_q[p] <= wrQual && ({bus.mhart, bus.rd0a} == {bus.fhart, rsA[p]});
      end
      bypData_q <= bus.rd0d;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rsD[p] = '0;
      if (running && valid_q[p]) begin
        rsD[p] = byp_q[p] ? bypData_q : bankRd[p];
      end
    end
  end
`else
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rsD[p] = '0;
      if (running && valid_q[p]) begin
        rsD[p] = bankRd[p];
      end
    end
  end
`endif

  assign bus.rs1d = rsD[0];
  assign bus.rs2d = rsD[1];
  assign bus.rdy  = running;

endmodule

// File: tb/tb_t5_mrf.sv
// Directed self-checking bench for t5_mrf with default parameters (4 harts x 32 regs x 32 bits).
module tb_t5_mrf;

  logic sclk;
  logic srst;
  int   checks   = 0;
  int   failures = 0;

  t5_mrf_if #(.XLEN(32), .HW(2), .RW(5)) bus ();

  t5_mrf #(.XLEN(32), .HARTS(4), .NREG(32)) dut (
    .sclk (sclk),
    .srst (srst),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one set of inputs, clock once, and leave the bench 1 time unit after the edge.
  task automatic applyStimulus(input logic sena, input logic [1:0] fhart, input logic [4:0] rs1a,
                               input logic [4:0] rs2a, input logic [1:0] mhart, input logic [4:0] rd0a,
                               input logic [31:0] rd0d, input logic mwre);
    bus.sena  = sena;
    bus.fhart = fhart;
    bus.rs1a  = rs1a;
    bus.rs2a  = rs2a;
    bus.mhart = mhart;
    bus.rd0a  = rd0a;
    bus.rd0d  = rd0d;
    bus.mwre  = mwre;
    @(posedge sclk);
    #1;
  endtask

  task automatic readRegs(input logic [1:0] h, input logic [4:0] a1, input logic [4:0] a2);
    applyStimulus(1'b1, h, a1, a2, 2'd0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic writeReg(input logic [1:0] h, input logic [4:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 2'd0, 5'd0, 5'd0, h, a, d, 1'b1);
  endtask

  initial begin
    int          earlyRdy;
    int          nonZero;
    logic [31:0] expColl;

`ifdef T5_MRF_BYPASS_EN
    expColl = 32'hB;
`else
    expColl = 32'hA;
`endif

    // Power-up reset: two edges, then the 128-edge clear sweep.
    srst = 1'b1;
    applyStimulus(1'b0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 32'h0, 1'b0);
    checkOutput("reset_rdy", 32'(bus.rdy), 32'd0);
    checkOutput("reset_rs1d", bus.rs1d, 32'h0);
    checkOutput("reset_rs2d", bus.rs2d, 32'h0);
    srst = 1'b0;

    earlyRdy = 0;
    for (int i = 1; i <= 127; i++) begin
      applyStimulus(1'b0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 32'h0, 1'b0);
      if (bus.rdy !== 1'b0) earlyRdy++;
    end
    checkOutput("sweep1_rdy_early", 32'(earlyRdy), 32'd0);
    applyStimulus(1'b0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 32'h0, 1'b0);
    checkOutput("sweep1_rdy_edge128", 32'(bus.rdy), 32'd1);

    nonZero = 0;
    for (int h = 0; h < 4; h++) begin
      for (int r = 0; r < 32; r++) begin
        readRegs(2'(h), 5'(r), 5'(31 - r));
        if (bus.rs1d !== 32'h0 || bus.rs2d !== 32'h0) nonZero++;
      end
    end
    checkOutput("clear_all_zero", 32'(nonZero), 32'd0);

    // Hart isolation on the same register number.
    writeReg(2'd1, 5'd5, 32'hDEADBEEF);
    writeReg(2'd2, 5'd5, 32'h12345678);
    readRegs(2'd1, 5'd5, 5'd5);
    checkOutput("iso_h1_rs1", bus.rs1d, 32'hDEADBEEF);
    checkOutput("iso_h1_rs2", bus.rs2d, 32'hDEADBEEF);
    readRegs(2'd2, 5'd5, 5'd5);
    checkOutput("iso_h2_rs2", bus.rs2d, 32'h12345678);
    checkOutput("iso_h2_rs1", bus.rs1d, 32'h12345678);
    readRegs(2'd0, 5'd5, 5'd5);
    checkOutput("iso_h0_x5", bus.rs1d, 32'h0);
    readRegs(2'd3, 5'd5, 5'd5);
    checkOutput("iso_h3_x5", bus.rs2d, 32'h0);

    // x0 is hardwired to zero; ports are independent.
    writeReg(2'd0, 5'd0, 32'hFFFFFFFF);
    readRegs(2'd0, 5'd0, 5'd0);
    checkOutput("x0_rs1", bus.rs1d, 32'h0);
    checkOutput("x0_rs2", bus.rs2d, 32'h0);
    writeReg(2'd0, 5'd3, 32'h00000033);
    readRegs(2'd0, 5'd3, 5'd0);
    checkOutput("indep_rs1_x3", bus.rs1d, 32'h00000033);
    checkOutput("indep_rs2_x0", bus.rs2d, 32'h0);

    // Same-edge read/write collision on hart3 x7.
    writeReg(2'd3, 5'd7, 32'hA);
    applyStimulus(1'b1, 2'd3, 5'd7, 5'd7, 2'd3, 5'd7, 32'hB, 1'b1);
    checkOutput("coll_rs1", bus.rs1d, expColl);
    checkOutput("coll_rs2", bus.rs2d, expColl);
    readRegs(2'd3, 5'd7, 5'd7);
    checkOutput("coll_after_rs1", bus.rs1d, 32'hB);
    checkOutput("coll_after_rs2", bus.rs2d, 32'hB);
    applyStimulus(1'b1, 2'd2, 5'd7, 5'd7, 2'd3, 5'd7, 32'hC, 1'b1);
    checkOutput("coll_other_hart", bus.rs1d, 32'h0);
    readRegs(2'd3, 5'd7, 5'd0);
    checkOutput("coll_other_written", bus.rs1d, 32'hC);

    // Stall: outputs hold and no write lands.
    readRegs(2'd1, 5'd5, 5'd5);
    checkOutput("stall_pre", bus.rs1d, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'd0, 5'd1, 5'd2, 2'd1, 5'd5, 32'h11111111, 1'b1);
    checkOutput("stall1_rs1", bus.rs1d, 32'hDEADBEEF);
    checkOutput("stall1_rs2", bus.rs2d, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'd2, 5'd0, 5'd3, 2'd0, 5'd9, 32'h22222222, 1'b1);
    checkOutput("stall2_rs1", bus.rs1d, 32'hDEADBEEF);
    checkOutput("stall2_rs2", bus.rs2d, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'd3, 5'd4, 5'd0, 2'd2, 5'd11, 32'h33333333, 1'b1);
    checkOutput("stall3_rs1", bus.rs1d, 32'hDEADBEEF);
    checkOutput("stall3_rs2", bus.rs2d, 32'hDEADBEEF);
    readRegs(2'd1, 5'd5, 5'd5);
    checkOutput("stall_no_write_h1x5", bus.rs1d, 32'hDEADBEEF);
    readRegs(2'd0, 5'd9, 5'd9);
    checkOutput("stall_no_write_h0x9", bus.rs1d, 32'h0);
    readRegs(2'd2, 5'd11, 5'd11);
    checkOutput("stall_no_write_h2x11", bus.rs2d, 32'h0);

    // Reset during RUN, then a second reset at sweep cycle 50.
    srst = 1'b1;
    applyStimulus(1'b1, 2'd1, 5'd5, 5'd5, 2'd2, 5'd6, 32'h66, 1'b1);
    checkOutput("runrst_rdy", 32'(bus.rdy), 32'd0);
    checkOutput("runrst_rs1d", bus.rs1d, 32'h0);
    checkOutput("runrst_rs2d", bus.rs2d, 32'h0);
    srst = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 3) begin
        readRegs(2'd1, 5'd5, 5'd5);
        checkOutput("clr_forced_zero", bus.rs1d, 32'h0);
      end else begin
        applyStimulus(1'b1, 2'd0, 5'd0, 5'd0, 2'd0, 5'd1, 32'h55, 1'b1);
      end
    end
    srst = 1'b1;
    applyStimulus(1'b1, 2'd0, 5'd0, 5'd0, 2'd0, 5'd1, 32'h55, 1'b1);
    checkOutput("midrst_rdy", 32'(bus.rdy), 32'd0);
    srst = 1'b0;

    earlyRdy = 0;
    for (int i = 1; i <= 127; i++) begin
      applyStimulus(1'b1, 2'd0, 5'd1, 5'd1, 2'd0, 5'd1, 32'h55, 1'b1);
      if (bus.rdy !== 1'b0) earlyRdy++;
    end
    checkOutput("sweep2_rdy_early", 32'(earlyRdy), 32'd0);
    applyStimulus(1'b0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 32'h0, 1'b0);
    checkOutput("sweep2_rdy_edge128", 32'(bus.rdy), 32'd1);

    readRegs(2'd0, 5'd1, 5'd1);
    checkOutput("sweep2_h0x1", bus.rs1d, 32'h0);
    readRegs(2'd1, 5'd5, 5'd5);
    checkOutput("sweep2_h1x5", bus.rs1d, 32'h0);
    readRegs(2'd3, 5'd7, 5'd7);
    checkOutput("sweep2_h3x7", bus.rs2d, 32'h0);
    writeReg(2'd0, 5'd1, 32'h55);
    readRegs(2'd0, 5'd1, 5'd1);
    checkOutput("post_sweep_write", bus.rs1d, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t5_mrf.md
T5_MRF -- requirements
Module: t5_mrf

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register data width.
REQ-002 SHALL provide parameter HARTS, default 4, hart count; power of two, 2..8.
REQ-003 SHALL provide parameter NREG, default 32, architectural registers per hart; 16 (RV32E) or 32.
REQ-004 SHALL derive localparams HW = log2(HARTS), RW = log2(NREG), AW = HW+RW.
REQ-005 SHALL have port sclk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port srst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port sena, input, 1, pipeline enable; low = stall.
REQ-008 SHALL have ports fhart (input, HW), rs1a (input, RW) and rs2a (input, RW): read hart and source addresses.
REQ-009 SHALL have ports rs1d and rs2d, output, XLEN, read data.
REQ-010 SHALL have ports mhart (input, HW), rd0a (input, RW), rd0d (input, XLEN) and mwre (input, 1): write hart, address, data and write enable.
REQ-011 SHALL have port rdy, output, 1, high when the clear sweep is done and the file is accepting accesses.

Function
REQ-012 SHALL store HARTS*NREG entries, addressed {hart, reg}.
REQ-013 SHALL sample read addresses on a rising edge with sena=1 and present data on rs1d/rs2d one cycle later (latency 1).
REQ-014 SHALL hold rs1d/rs2d and perform no write while sena=0.
REQ-015 SHALL write rd0d to {mhart, rd0a} on an edge where sena=1, mwre=1, rdy=1 and rd0a!=0.
REQ-016 SHALL return 0 for any read of register 0, regardless of array contents.
REQ-017 SHALL ignore writes with rd0a=0.
REQ-018 SHALL run a two-state FSM: CLR, then RUN.
- CLR: counter walks 0..HARTS*NREG-1, writing 0 one entry per cycle independent of sena; rdy=0; external writes ignored; rs1d/rs2d forced to 0.
- On the edge where the counter equals HARTS*NREG-1: go to RUN and set rdy=1.
- RUN is terminal until srst.
REQ-019 SHALL make the clear take exactly HARTS*NREG cycles after srst deasserts; with defaults, rdy rises on the 128th edge.
REQ-020 SHALL treat a read and write to the same port address with different harts as independent accesses, with no bypass.
REQ-021 SHALL evaluate both read ports independently; rs1a==rs2a is legal and returns identical data.

Reset
REQ-022 SHALL, while srst=1, force state=CLR, counter=0, rdy=0, rs1d=0 and rs2d=0.
REQ-023 SHALL restart the sweep from entry 0 when srst is asserted mid-sweep or during RUN.
REQ-024 SHALL never write array contents in the same cycle that srst=1.

Configuration
REQ-025 SHALL honour macro T5_MRF_BYPASS_EN.
- Defined: a read sampled on the same edge as a qualifying write to the same {hart, reg} returns rd0d (write-first), on each port independently.
- Undefined: such a read returns the pre-write contents (read-first), and no forwarding logic is present.

Structure
REQ-026 SHALL take XLEN and HARTS defaults and the FSM state enum (CLR, RUN) from shared package t5_pkg.
REQ-027 SHALL instantiate one sub-module t5_rfbank per read port. Each bank is 1 write port and 1 synchronous read port of depth HARTS*NREG, with all banks written identically.
REQ-028 SHALL keep the clear counter, the FSM and the x0/bypass muxing in t5_mrf, not in t5_rfbank.

Verification
REQ-029 SHALL cover reset sweep: srst high 2 cycles then low. Required response: rdy=0 for 127 edges and rdy=1 on edge 128; every {h, r} then reads 0.
REQ-030 SHALL cover hart isolation: write 0xDEADBEEF to hart1 x5 and 0x12345678 to hart2 x5. Required response: fhart=1 rs1a=5 gives 0xDEADBEEF next cycle; fhart=2 rs2a=5 gives 0x12345678.
REQ-031 SHALL cover x0: write 0xFFFFFFFF to hart0 x0. Required response: rs1a=0 and rs2a=0 both read 0.
REQ-032 SHALL cover same-cycle collision: hart3 x7 holds 0xA, then write 0xB to hart3 x7 while reading it. Required response: 0xB with T5_MRF_BYPASS_EN, 0xA without; the next read gives 0xB in both builds.
REQ-033 SHALL cover stall: hold sena=0 with mwre=1 and changing addresses for 3 cycles. Required response: outputs are unchanged and a later read shows no write occurred.
REQ-034 SHALL cover reset mid-sweep: assert srst at sweep cycle 50, release it, and write hart0 x1 with 0x55 during the sweep. Required response: rdy rises exactly 128 edges after release and x1 reads 0.
